alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a registered logic ALU (AND/ORR/EOR/BIC).
// Define ALU_ARBITER_FLAGS_EN to add the rsp_n / rsp_z result flag outputs.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result
`ifdef ALU_ARBITER_FLAGS_EN
    ,
    output logic         rsp_n,
    output logic         rsp_z
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ORR = 2'b01;
    localparam logic [1:0] OP_EOR = 2'b10;
    localparam logic [1:0] OP_BIC = 2'b11;

    function automatic logic [N-1:0] alu_f(input logic [1:0] op,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic [N-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_ORR:  r = a | b;
            OP_EOR:  r = a ^ b;
            OP_BIC:  r = a & ~b;
            default: r = {N{1'b0}};
        endcase
        return r;
    endfunction

    state_t       state_q,  state_d;
    logic         last_q,   last_d;
    logic [1:0]   op_q,     op_d;
    logic [N-1:0] a_q,      a_d;
    logic [N-1:0] b_q,      b_d;
    logic         id_q,     id_d;
    logic [N-1:0] result_q, result_d;
    logic         valid_q,  valid_d;
`ifdef ALU_ARBITER_FLAGS_EN
    logic         n_q, n_d;
    logic         z_q, z_d;
`endif

    logic         grant_s;
    logic         idle_s;
    logic         accept_s;

    // Round-robin pick: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // rst_n gates the readies so nothing looks accepted while reset is held.
    assign idle_s     = (state_q == S_IDLE) && rst_n;
    assign req0_ready = idle_s && req0_valid && !grant_s;
    assign req1_ready = idle_s && req1_valid &&  grant_s;
    assign accept_s   = req0_ready || req1_ready;

    // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        result_d = result_q;
        valid_d  = valid_q;
`ifdef ALU_ARBITER_FLAGS_EN
        n_d      = n_q;
        z_d      = z_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_EXEC;
                    last_d  = grant_s;
                    id_d    = grant_s;
                    op_d    = grant_s ? req1_op : req0_op;
                    a_d     = grant_s ? req1_a  : req0_a;
                    b_d     = grant_s ? req1_b  : req0_b;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d  = S_RESP;
                valid_d  = 1'b1;
                result_d = alu_f(op_q, a_q, b_q);
`ifdef ALU_ARBITER_FLAGS_EN
                n_d      = result_d[N-1];
                z_d      = (result_d == {N{1'b0}});
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            op_q     <= 2'b00;
            a_q      <= {N{1'b0}};
            b_q      <= {N{1'b0}};
            id_q     <= 1'b0;
            result_q <= {N{1'b0}};
            valid_q  <= 1'b0;
`ifdef ALU_ARBITER_FLAGS_EN
            n_q      <= 1'b0;
            z_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
            valid_q  <= valid_d;
`ifdef ALU_ARBITER_FLAGS_EN
            n_q      <= n_d;
            z_q      <= z_d;
`endif
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
`ifdef ALU_ARBITER_FLAGS_EN
    assign rsp_n      = n_q;
    assign rsp_z      = z_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, single op, tie round-robin,
// backpressure, BIC (with flags when ALU_ARBITER_FLAGS_EN is defined), reset mid-operation.
module tb_alu_arbiter;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [1:0]   req0_op;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [1:0]   req1_op;
    logic [N-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_result;
`ifdef ALU_ARBITER_FLAGS_EN
    logic         rsp_n, rsp_z;
`endif

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef ALU_ARBITER_FLAGS_EN
        ,
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", rsp_result); end
        checks++;
        if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", rsp_id); end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_readies: got %b want 00", {req0_ready, req1_ready});
        end
        idle_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h2; req0_b = 32'h1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_grant: got %b want 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid: got %b want 0", rsp_valid); end
        step();
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        checks++;
        if (rsp_result !== 32'h0) begin errors++; $display("FAIL single_result: got %h want 0", rsp_result); end
        checks++;
        if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", rsp_id); end
`ifdef ALU_ARBITER_FLAGS_EN
        checks++;
        if ({rsp_n, rsp_z} !== 2'b01) begin errors++; $display("FAIL single_flags: got nz=%b want 01", {rsp_n, rsp_z}); end
`endif
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", rsp_valid); end
    endtask

    task automatic test_tie();
        logic [N-1:0] exp_res [2];
        exp_res[0] = 32'h0000000F;
        exp_res[1] = 32'h50000005;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'hF;        req0_b = 32'h5;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'h55555555; req1_b = 32'hF222222F;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL tie_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready},
                                   (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
            checks++;
            if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
                errors++; $display("FAIL tie_exec[%0d]: got rdy/valid %b want 000", i, {req0_ready, req1_ready, rsp_valid});
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== i[0] || rsp_result !== exp_res[i % 2]) begin
                errors++; $display("FAIL tie_rsp[%0d]: got v=%b id=%b res=%h want v=1 id=%b res=%h",
                                   i, rsp_valid, rsp_id, rsp_result, i[0], exp_res[i % 2]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] held;
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hFFFFFFFF; req1_b = 32'h0F0F0F0F;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h1234; req0_b = 32'h1;
        step();
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'hF0F0F0F0 || rsp_id !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%b res=%h want v=1 id=1 res=f0f0f0f0",
                                   i, rsp_valid, rsp_id, rsp_result);
            end
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++; $display("FAIL bp_readies[%0d]: got %b want 00", i, {req0_ready, req1_ready});
            end
            req0_a = req0_a + 32'h11;
            req1_a = 32'h0;
            step();
        end
        checks++;
        if (rsp_result !== 32'hF0F0F0F0) begin errors++; $display("FAIL bp_stable: got %h want f0f0f0f0 (first %h)", rsp_result, held); end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
        idle_inputs();
    endtask

    task automatic test_bic();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'h80000001; req0_b = 32'h00000001;
        step();
        req0_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h80000000 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL bic_rsp: got v=%b id=%b res=%h want v=1 id=0 res=80000000", rsp_valid, rsp_id, rsp_result);
        end
`ifdef ALU_ARBITER_FLAGS_EN
        checks++;
        if ({rsp_n, rsp_z} !== 2'b10) begin errors++; $display("FAIL bic_flags: got nz=%b want 10", {rsp_n, rsp_z}); end
`endif
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h3; req0_b = 32'h1;
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid[%0d]: got %b want 0", i, rsp_valid); end
            step();
        end
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'hA; req0_b = 32'h5;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hF; req1_b = 32'hF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rstmid_tie: got %b want 10", {req0_ready, req1_ready});
        end
        step();
        idle_inputs();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'hF) begin
            errors++; $display("FAIL rstmid_rsp: got v=%b id=%b res=%h want v=1 id=0 res=f", rsp_valid, rsp_id, rsp_result);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_bic();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
